// File: rtl/caravel_sram_scan_ctrl_if.sv
// SRAM-side bus between the scan controller (master) and the attached OpenRAM macros (slave).
interface caravel_sram_scan_ctrl_if #(
    parameter int NUM_SRAMS = 16,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 16
);
    logic [NUM_SRAMS-1:0]        sram_csb0;
    logic                        sram_web0;
    logic [ADDR_W-1:0]           sram_addr0;
    logic [DATA_W-1:0]           sram_din0;
    logic [3:0]                  sram_wmask0;
    logic [NUM_SRAMS-1:0]        sram_csb1;
    logic                        sram_web1;
    logic [ADDR_W-1:0]           sram_addr1;
    logic [DATA_W-1:0]           sram_din1;
    logic [3:0]                  sram_wmask1;
    logic [NUM_SRAMS*DATA_W-1:0] sram_dout0_all;
    logic [NUM_SRAMS*DATA_W-1:0] sram_dout1_all;

    modport master (
        output sram_csb0, sram_web0, sram_addr0, sram_din0, sram_wmask0,
        output sram_csb1, sram_web1, sram_addr1, sram_din1, sram_wmask1,
        input  sram_dout0_all, sram_dout1_all
    );

    modport slave (
        input  sram_csb0, sram_web0, sram_addr0, sram_din0, sram_wmask0,
        input  sram_csb1, sram_web1, sram_addr1, sram_din1, sram_wmask1,
        output sram_dout0_all, sram_dout1_all
    );
endinterface

// File: rtl/caravel_sram_scan_ctrl.sv
// Serial scan-chain controller driving up to NUM_SRAMS OpenRAM macros from a few GPIO pins.
// Optional macro SRAM_SEL_CHECK_EN adds a sticky sel_err output for out-of-range macro selects.
module caravel_sram_scan_ctrl #(
    parameter int NUM_SRAMS = 16,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic scan_en,
    input  logic scan_in,
    output logic scan_out,
    input  logic sram_load,
    input  logic global_csb,
`ifdef SRAM_SEL_CHECK_EN
    output logic sel_err,
`endif
    caravel_sram_scan_ctrl_if.master sram
);

    localparam int SEL_W      = 4;
    localparam int WMASK1_LSB = 0;
    localparam int WEB1_BIT   = 4;
    localparam int CSB1_BIT   = 5;
    localparam int DIN1_LSB   = 6;
    localparam int ADDR1_LSB  = DIN1_LSB + DATA_W;
    localparam int WMASK0_LSB = ADDR1_LSB + ADDR_W;
    localparam int WEB0_BIT   = WMASK0_LSB + 4;
    localparam int CSB0_BIT   = WEB0_BIT + 1;
    localparam int DIN0_LSB   = CSB0_BIT + 1;
    localparam int ADDR0_LSB  = DIN0_LSB + DATA_W;
    localparam int SEL_LSB    = ADDR0_LSB + ADDR_W;
    localparam int CHAIN_W    = SEL_LSB + SEL_W;

    logic [CHAIN_W-1:0] r_chain;
    logic [SEL_W-1:0]   w_sel;
    logic [SEL_W-1:0]   r_selQ;
    logic               w_csb0Fld;
    logic               w_web0Fld;
    logic               w_csb1Fld;
    logic               w_web1Fld;
    logic               w_strobe;
    logic               w_selOk;
    logic               r_capture;
    logic               r_rd0Pend;
    logic               r_rd1Pend;
    logic [DATA_W-1:0]  r_dout0Q;
    logic [DATA_W-1:0]  r_dout1Q;
    logic [DATA_W-1:0]  w_dout0Sel;
    logic [DATA_W-1:0]  w_dout1Sel;

    assign w_sel     = r_chain[SEL_LSB +: SEL_W];
    assign w_csb0Fld = r_chain[CSB0_BIT];
    assign w_web0Fld = r_chain[WEB0_BIT];
    assign w_csb1Fld = r_chain[CSB1_BIT];
    assign w_web1Fld = r_chain[WEB1_BIT];
    assign w_strobe  = ~global_csb & ~scan_en;
    assign scan_out  = r_chain[CHAIN_W-1];

    assign sram.sram_web0   = w_web0Fld;
    assign sram.sram_addr0  = r_chain[ADDR0_LSB +: ADDR_W];
    assign sram.sram_din0   = r_chain[DIN0_LSB +: DATA_W];
    assign sram.sram_wmask0 = r_chain[WMASK0_LSB +: 4];
    assign sram.sram_web1   = w_web1Fld;
    assign sram.sram_addr1  = r_chain[ADDR1_LSB +: ADDR_W];
    assign sram.sram_din1   = r_chain[DIN1_LSB +: DATA_W];
    assign sram.sram_wmask1 = r_chain[WMASK1_LSB +: 4];

    // Chip selects are only ever low during a strobe cycle; reset forces them high too.
    for (genvar k = 0; k < NUM_SRAMS; k++) begin : g_csb
        assign sram.sram_csb0[k] = reset | global_csb | scan_en | w_csb0Fld | (w_sel != SEL_W'(k));
        assign sram.sram_csb1[k] = reset | global_csb | scan_en | w_csb1Fld | (w_sel != SEL_W'(k));
    end

`ifdef SRAM_SEL_CHECK_EN
    logic r_selErr;

    assign w_selOk = (int'(w_sel) < NUM_SRAMS);
    assign sel_err = r_selErr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_selErr <= 1'b0;
        end else if (w_strobe && !w_selOk) begin
            r_selErr <= 1'b1;
        end
    end
`else
    assign w_selOk = 1'b1;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_chain <= '0;
        end else if (scan_en) begin
            r_chain <= {r_chain[CHAIN_W-2:0], scan_in};
        end else if (sram_load) begin
            r_chain[DIN0_LSB +: DATA_W] <= r_dout0Q;
            r_chain[DIN1_LSB +: DATA_W] <= r_dout1Q;
        end
    end

    // Strobe stage: remember which ports performed a read and from which macro.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_capture <= 1'b0;
            r_rd0Pend <= 1'b0;
            r_rd1Pend <= 1'b0;
            r_selQ    <= '0;
        end else begin
            r_capture <= w_strobe;
            if (w_strobe) begin
                r_rd0Pend <= w_selOk & ~w_csb0Fld & w_web0Fld;
                r_rd1Pend <= w_selOk & ~w_csb1Fld & w_web1Fld;
                r_selQ    <= w_sel;
            end else begin
                r_rd0Pend <= 1'b0;
                r_rd1Pend <= 1'b0;
            end
        end
    end

    // An out-of-range select matches no macro and yields zero.
    always_comb begin
        w_dout0Sel = '0;
        w_dout1Sel = '0;
        for (int k = 0; k < NUM_SRAMS; k++) begin
            if (r_selQ == SEL_W'(k)) begin
                w_dout0Sel = sram.sram_dout0_all[k*DATA_W +: DATA_W];
                w_dout1Sel = sram.sram_dout1_all[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dout0Q <= '0;
            r_dout1Q <= '0;
        end else if (r_capture) begin
            r_dout0Q <= r_rd0Pend ? w_dout0Sel : '0;
            r_dout1Q <= r_rd1Pend ? w_dout1Sel : '0;
        end
    end

endmodule

// File: tb/tb_caravel_sram_scan_ctrl.sv
// Randomized bench for caravel_sram_scan_ctrl with a behavioural memory/command model.
// Build with SRAM_SEL_CHECK_EN defined to also check the sticky sel_err output.
module tb_caravel_sram_scan_ctrl;

    localparam int NS        = 11;
    localparam int CW        = 112;
    localparam int SP_MACRO  = 9;

    logic clock;
    logic reset;
    logic scan_en;
    logic scan_in;
    logic scan_out;
    logic sram_load;
    logic global_csb;
`ifdef SRAM_SEL_CHECK_EN
    logic selErr;
`endif

    int compared   = 0;
    int mismatched = 0;

    logic [CW-1:0] expChain;
    logic [31:0]   expRd0;
    logic [31:0]   expRd1;
    logic          expSelErr;
    logic [31:0]   refMem [NS][8];
    logic [31:0]   mem    [NS][8];
    logic [31:0]   dout0  [NS];
    logic [31:0]   dout1  [NS];
    logic          memReady;

    caravel_sram_scan_ctrl_if #(.NUM_SRAMS(NS)) sramIf ();

    caravel_sram_scan_ctrl #(.NUM_SRAMS(NS)) dut (
        .clock      (clock),
        .reset      (reset),
        .scan_en    (scan_en),
        .scan_in    (scan_in),
        .scan_out   (scan_out),
        .sram_load  (sram_load),
        .global_csb (global_csb),
`ifdef SRAM_SEL_CHECK_EN
        .sel_err    (selErr),
`endif
        .sram       (sramIf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] initWord(int k, int a);
        return {8'(k), 8'(a), 16'hC3A5};
    endfunction

    // Behavioural OpenRAM macros; macro SP_MACRO is single-port (port 1 ignored, dout1 tied low).
    always @(posedge clock) begin
        if (memReady !== 1'b1) begin
            for (int k = 0; k < NS; k++)
                for (int a = 0; a < 8; a++)
                    mem[k][a] <= initWord(k, a);
            memReady <= 1'b1;
        end else begin
            for (int k = 0; k < NS; k++) begin
                if (!sramIf.sram_csb0[k]) begin
                    if (!sramIf.sram_web0) begin
                        for (int b = 0; b < 4; b++)
                            if (sramIf.sram_wmask0[b])
                                mem[k][sramIf.sram_addr0[2:0]][8*b +: 8] <= sramIf.sram_din0[8*b +: 8];
                    end else begin
                        dout0[k] <= mem[k][sramIf.sram_addr0[2:0]];
                    end
                end
                if (!sramIf.sram_csb1[k] && k != SP_MACRO) begin
                    if (!sramIf.sram_web1) begin
                        for (int b = 0; b < 4; b++)
                            if (sramIf.sram_wmask1[b])
                                mem[k][sramIf.sram_addr1[2:0]][8*b +: 8] <= sramIf.sram_din1[8*b +: 8];
                    end else begin
                        dout1[k] <= mem[k][sramIf.sram_addr1[2:0]];
                    end
                end
            end
        end
    end

    always_comb begin
        sramIf.sram_dout0_all = '0;
        sramIf.sram_dout1_all = '0;
        for (int k = 0; k < NS; k++) begin
            sramIf.sram_dout0_all[k*32 +: 32] = dout0[k];
            if (k != SP_MACRO) sramIf.sram_dout1_all[k*32 +: 32] = dout1[k];
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [CW-1:0] makeCmd(
        input logic [3:0] sel,
        input logic [15:0] a0, input logic [31:0] d0, input logic c0, input logic w0, input logic [3:0] m0,
        input logic [15:0] a1, input logic [31:0] d1, input logic c1, input logic w1, input logic [3:0] m1);
        return {sel, a0, d0, c0, w0, m0, a1, d1, c1, w1, m1};
    endfunction

    // One full tester transaction: shift in cmd (checking old chain), strobe, idle, load.
    task automatic applyStimulus(input logic [CW-1:0] cmd, input bit doStrobe, input bit resetMid, input int spur);
        logic [3:0]    sel;
        logic [15:0]   a0, a1;
        logic [31:0]   d0, d1, rd0, rd1;
        logic          c0, w0, c1, w1, selOk;
        logic [3:0]    m0, m1;
        logic [NS-1:0] ones, e0, e1;
        {sel, a0, d0, c0, w0, m0, a1, d1, c1, w1, m1} = cmd;
        selOk = (int'(sel) < NS);
        ones  = '1;
        for (int i = 0; i < CW; i++) begin
            @(negedge clock);
            scan_en    = 1'b1;
            scan_in    = cmd[CW-1-i];
            sram_load  = 1'b0;
            global_csb = (i == spur) ? 1'b0 : 1'b1;
            #2;
            checkOutput("scanOut", 128'(scan_out), 128'(expChain[CW-1-i]));
            checkOutput("csbShift", 128'({sramIf.sram_csb1, sramIf.sram_csb0}), 128'({ones, ones}));
        end
        expChain = cmd;

        @(negedge clock);
        scan_en    = 1'b0;
        global_csb = doStrobe ? 1'b0 : 1'b1;
        #2;
        e0 = ones;
        e1 = ones;
        if (doStrobe && selOk && !c0) e0[sel] = 1'b0;
        if (doStrobe && selOk && !c1) e1[sel] = 1'b0;
        checkOutput("csb0Strobe", 128'(sramIf.sram_csb0), 128'(e0));
        checkOutput("csb1Strobe", 128'(sramIf.sram_csb1), 128'(e1));
        checkOutput("port0Bus", 128'({sramIf.sram_addr0, sramIf.sram_din0, sramIf.sram_web0, sramIf.sram_wmask0}),
                    128'({a0, d0, w0, m0}));
        checkOutput("port1Bus", 128'({sramIf.sram_addr1, sramIf.sram_din1, sramIf.sram_web1, sramIf.sram_wmask1}),
                    128'({a1, d1, w1, m1}));
        if (doStrobe) begin
            rd0 = (selOk && !c0 && w0) ? refMem[sel][a0[2:0]] : 32'h0;
            rd1 = (selOk && !c1 && w1 && sel != 4'(SP_MACRO)) ? refMem[sel][a1[2:0]] : 32'h0;
            if (selOk && !c0 && !w0)
                for (int b = 0; b < 4; b++)
                    if (m0[b]) refMem[sel][a0[2:0]][8*b +: 8] = d0[8*b +: 8];
            if (selOk && !c1 && !w1 && sel != 4'(SP_MACRO))
                for (int b = 0; b < 4; b++)
                    if (m1[b]) refMem[sel][a1[2:0]][8*b +: 8] = d1[8*b +: 8];
            expRd0 = rd0;
            expRd1 = rd1;
            if (!selOk) expSelErr = 1'b1;
        end

        @(negedge clock);
        if (resetMid) begin
            reset      = 1'b1;
            global_csb = 1'b0;
            #2;
            checkOutput("rstMidScanOut", 128'(scan_out), 128'(0));
            checkOutput("rstMidCsb", 128'({sramIf.sram_csb1, sramIf.sram_csb0}), 128'({ones, ones}));
            expChain  = '0;
            expRd0    = '0;
            expRd1    = '0;
            expSelErr = 1'b0;
        end else begin
            global_csb = 1'b1;
            #2;
            checkOutput("csbIdle", 128'({sramIf.sram_csb1, sramIf.sram_csb0}), 128'({ones, ones}));
        end

        @(negedge clock);
        reset      = 1'b0;
        global_csb = 1'b1;
        sram_load  = 1'b1;
        #2;
`ifdef SRAM_SEL_CHECK_EN
        checkOutput("selErr", 128'(selErr), 128'(expSelErr));
`endif
        expChain[91:60] = expRd0;
        expChain[37:6]  = expRd1;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0]    rSel;
        logic [15:0]   rA0, rA1;
        logic [NS-1:0] allOnes;
        bit            rStrobe, rReset;
        int            rSpur;
        allOnes    = '1;
        reset      = 1'b1;
        scan_en    = 1'b0;
        scan_in    = 1'b0;
        sram_load  = 1'b0;
        global_csb = 1'b0;
        expChain   = '0;
        expRd0     = '0;
        expRd1     = '0;
        expSelErr  = 1'b0;
        for (int k = 0; k < NS; k++)
            for (int a = 0; a < 8; a++)
                refMem[k][a] = initWord(k, a);

        repeat (2) @(negedge clock);
        #2;
        checkOutput("rstScanOut", 128'(scan_out), 128'(0));
        checkOutput("rstCsb0", 128'(sramIf.sram_csb0), 128'(allOnes));
        checkOutput("rstCsb1", 128'(sramIf.sram_csb1), 128'(allOnes));
`ifdef SRAM_SEL_CHECK_EN
        checkOutput("rstSelErr", 128'(selErr), 128'(0));
`endif
        @(negedge clock);
        reset      = 1'b0;
        global_csb = 1'b1;

        $display("[TB] directed sequence");
        applyStimulus(makeCmd(4'd3, 16'd1, 32'd3, 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'hF), 1'b1, 1'b0, -1);
        applyStimulus(makeCmd(4'd3, 16'd2, 32'd24, 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'hF), 1'b1, 1'b0, -1);
        applyStimulus(makeCmd(4'd3, 16'd1, 32'hFFFF, 1'b0, 1'b1, 4'hF, 16'd2, 32'hFFFF, 1'b0, 1'b1, 4'hF), 1'b1, 1'b0, -1);
        applyStimulus(makeCmd(4'd9, 16'd1, 32'hDEADBEEF, 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'h0), 1'b1, 1'b0, -1);
        applyStimulus(makeCmd(4'd9, 16'd1, 32'd0, 1'b0, 1'b1, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'h0), 1'b1, 1'b0, -1);
        applyStimulus(makeCmd(4'd15, 16'd1, 32'd0, 1'b0, 1'b1, 4'hF, 16'd2, 32'd0, 1'b0, 1'b1, 4'hF), 1'b1, 1'b0, -1);
        applyStimulus(makeCmd(4'd3, 16'd1, 32'd0, 1'b0, 1'b1, 4'hF, 16'd2, 32'd0, 1'b0, 1'b1, 4'hF), 1'b1, 1'b1, -1);
        applyStimulus(makeCmd(4'd5, 16'd3, 32'd7, 1'b0, 1'b1, 4'hF, 16'd4, 32'd9, 1'b0, 1'b1, 4'hF), 1'b1, 1'b0, -1);
        applyStimulus(makeCmd(4'd1, 16'd0, 32'd0, 1'b0, 1'b1, 4'hF, 16'd1, 32'd0, 1'b0, 1'b1, 4'hF), 1'b0, 1'b0, 40);

        $display("[TB] randomized sequence");
        for (int t = 0; t < 30; t++) begin
            rSel = 4'($urandom_range(0, 15));
            rA0  = 16'($urandom_range(0, 7));
            rA1  = 16'($urandom_range(0, 7));
            if (rA1 == rA0) rA1 = rA0 ^ 16'd1;
            rStrobe = ($urandom_range(0, 5) != 0);
            rReset  = rStrobe && ($urandom_range(0, 9) == 0);
            rSpur   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, CW - 1)) : -1;
            applyStimulus(makeCmd(rSel,
                                  rA0, 32'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), 4'($urandom),
                                  rA1, 32'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), 4'($urandom)),
                          rStrobe, rReset, rSpur);
        end
        applyStimulus('0, 1'b0, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
